instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, PC value loaded at reset.
REQ-002 SHALL have parameter ADDR_W, default 8, instruction word-address width.
REQ-003 SHALL have ports: clk  input  1  sole clock, all state on posedge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: imem_req  output  1  one-cycle fetch request pulse.
REQ-006 SHALL have port: imem_addr  output  ADDR_W  word address, equal to current PC.
REQ-007 SHALL have port: imem_rvalid  input  1  read data valid, at least 1 cycle after imem_req.
REQ-008 SHALL have port: imem_rdata  input  16  instruction word.
REQ-009 SHALL have port: branch_taken  input  1  redirect pulse (Branch AND ALU zero).
REQ-010 SHALL have port: branch_target  input  ADDR_W  redirect address.
REQ-011 SHALL have port: out_valid  output  1  instruction available at FIFO head.
REQ-012 SHALL have port: out_ready  input  1  consumer accepts head this cycle.
REQ-013 SHALL have port: instr  output  16  FIFO head word, 0 when empty.
REQ-014 SHALL have ports: x1, x2  output  1 each  opcode bits instr[15], instr[14] to the controller, 0 when empty.

Function
REQ-015 SHALL keep one outstanding memory request at most; FSM states IDLE, WAIT, DROP.
REQ-016 IDLE: SHALL pulse imem_req when FIFO count <2 and branch_taken=0, increment PC by 1 (mod 2^ADDR_W) on that edge, go WAIT.
REQ-017 WAIT: SHALL push imem_rdata into FIFO on imem_rvalid, return to IDLE; a new request SHALL NOT issue in the same cycle.
REQ-018 Pop SHALL occur when out_valid & out_ready; simultaneous push and pop SHALL leave count unchanged, preserving order.
REQ-019 FIFO SHALL be 2 entries; issue rule (REQ-016) guarantees no push when full; out_valid = (count != 0).
REQ-020 branch_taken SHALL, on the same edge, set PC to branch_target, clear FIFO (count 0), suppress any push and pop.
REQ-021 branch_taken in WAIT without imem_rvalid SHALL go DROP; DROP SHALL discard the next imem_rvalid and go IDLE.
REQ-022 branch_taken coincident with imem_rvalid (WAIT or DROP) SHALL discard the data and go IDLE.
REQ-023 branch_taken in IDLE SHALL suppress imem_req that cycle; fetch from branch_target starts the following cycle.
REQ-024 imem_rvalid in IDLE SHALL be ignored.

Reset
REQ-025 On rst_n low, asynchronously: PC=RESET_PC, state IDLE, FIFO count 0, imem_req=0, out_valid=0, instr=0, x1=x2=0.
REQ-026 Reset mid-WAIT SHALL abandon the request; a later stray imem_rvalid in IDLE is ignored per REQ-024.
REQ-027 First imem_req SHALL assert the first posedge after rst_n deasserts, addr RESET_PC.

Configuration
REQ-028 With FETCH_PERF_CNT_EN defined: outputs perf_fetched[15:0] (pushes) and perf_flushed[15:0] (branch_taken events), saturating at 16'hFFFF, reset 0.
REQ-029 Without FETCH_PERF_CNT_EN: those ports and counters SHALL NOT exist; all other behaviour identical.

Structure
REQ-030 Shared package fetch_pkg SHALL hold ADDR_W default, INSTR_W=16, opcode bit positions (15,14), FSM state enum.
REQ-031 2-entry FIFO SHALL be a sub-module fetch_fifo (push, pop, flush, data, count); FSM and PC stay in instr_fetch.

Verification
REQ-032 Reset release, memory 1-cycle latency, out_ready=1 -> addresses 0,1,2 requested every 2 cycles; instr in order; x1/x2 track bits 15:14.
REQ-033 out_ready=0, 3 fetches attempted -> count saturates at 2, imem_req stops after 2nd response, resumes one cycle after first pop.
REQ-034 branch_taken target 8'h40 while WAIT, response arrives 2 cycles later -> that data dropped, next imem_addr 8'h40, out_valid 0 until its response.
REQ-035 branch_taken coincident with imem_rvalid and out_ready=1 -> no push, no pop, FIFO empty next cycle, state IDLE.
REQ-036 PC at 8'hFF fetch -> next imem_addr 8'h00.
REQ-037 rst_n low for 1 cycle mid-WAIT with 2 entries full -> all outputs reset values immediately, fetch restarts at RESET_PC; with FETCH_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and FSM state encodings for the instruction fetch unit.
package fetch_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int INSTR_W    = 16;
  localparam int X1_BIT     = 15;
  localparam int X2_BIT     = 14;

  typedef logic [1:0] fetchState_t;
  localparam fetchState_t ST_IDLE = 2'd0;
  localparam fetchState_t ST_WAIT = 2'd1;
  localparam fetchState_t ST_DROP = 2'd2;
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction FIFO; entry0 is always the head, so no pointers are needed.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [INSTR_W-1:0] pushData,
  output logic [INSTR_W-1:0] headData,
  output logic [1:0]         count
);
  logic [INSTR_W-1:0] entry0, entry1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= pushData;
          else               entry1 <= pushData;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever remains.
          if (count == 2'd1) entry0 <= pushData;
          else begin
            entry0 <= entry1;
            entry1 <= pushData;
          end
        end
        default: ;
      endcase
    end
  end

  assign headData = (count != 2'd0) ? entry0 : '0;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, single-outstanding memory request FSM and 2-deep FIFO.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/flush counters.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(8'h00)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr,
  output logic               x1,
  output logic               x2
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_flushed
`endif
);
  fetchState_t       state;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        count;
  logic              push, pop;

  // rst_n gates the request so it stays low while reset is held.
  assign imem_req  = rst_n && (state == ST_IDLE) && (count < 2'd2) && !branch_taken;
  assign imem_addr = pc;
  assign push      = (state == ST_WAIT) && imem_rvalid && !branch_taken;
  assign pop       = out_valid && out_ready && !branch_taken;
  assign out_valid = (count != 2'd0);
  assign x1        = instr[X1_BIT];
  assign x2        = instr[X2_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
    end else begin
      if (branch_taken)  pc <= branch_target;
      else if (imem_req) pc <= pc + ADDR_W'(1);
      case (state)
        ST_IDLE: if (imem_req) state <= ST_WAIT;
        ST_WAIT: begin
          if (imem_rvalid)       state <= ST_IDLE;
          else if (branch_taken) state <= ST_DROP;
        end
        ST_DROP: if (imem_rvalid) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  fetch_fifo uFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (branch_taken),
    .pushData (imem_rdata),
    .headData (instr),
    .count    (count)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 16'd0;
      perf_flushed <= 16'd0;
    end else begin
      if (push && perf_fetched != 16'hFFFF)         perf_fetched <= perf_fetched + 16'd1;
      if (branch_taken && perf_flushed != 16'hFFFF) perf_flushed <= perf_flushed + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: memory model, expected PC and expected FIFO queue.
module tb_instr_fetch;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req, imem_rvalid, branch_taken, out_valid, out_ready, x1, x2;
  logic [7:0]  imem_addr, branch_target;
  logic [15:0] imem_rdata, instr;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetched, perf_flushed;
`endif

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .x1(x1), .x2(x2)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  int          nChk = 0, nPass = 0;
  int          lat = 1, pendCnt = 0, nPush = 0, nBr = 0;
  logic [7:0]  expPc = 8'h00, pendAddr = 8'h00;
  logic [15:0] expQ[$];
  bit          pend = 0, outstanding = 0, dirty = 0;

  function automatic logic [15:0] memData(input logic [7:0] a);
    return {a ^ 8'hC3, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic cyc(input bit br, input logic [7:0] tgt, input bit rdy,
                     output logic req, output logic [7:0] addr);
    bit rv, popping;
    rv = pend && (pendCnt == 0);
    imem_rvalid = rv;
    imem_rdata  = rv ? memData(pendAddr) : 16'($urandom);
    if (rv) pend = 0;
    else if (pend) pendCnt--;
    branch_taken = br; branch_target = tgt; out_ready = rdy;
    #1;
    req = imem_req; addr = imem_addr;
    chk("out_valid", out_valid, expQ.size() != 0);
    if (expQ.size() == 0) chk("instr_empty", {x1, x2, instr}, 0);
    else begin
      chk("instr", instr, expQ[0]);
      chk("x1x2", {x1, x2}, expQ[0][15:14]);
    end
    if (br || outstanding) chk("req_blocked", req, 0);
    if (req) chk("imem_addr", addr, expPc);
    popping = (expQ.size() != 0) && rdy && !br;
    if (br) begin
      expQ.delete();
      nBr++;
    end else begin
      if (popping) void'(expQ.pop_front());
      if (rv && outstanding && !dirty) begin
        expQ.push_back(memData(pendAddr));
        nPush++;
      end
    end
    if (rv) outstanding = 0;
    if (br) begin
      expPc = tgt;
      if (outstanding) dirty = 1;
    end
    if (req) begin
      outstanding = 1; dirty = 0; expPc = expPc + 8'd1;
      pend = 1; pendCnt = lat - 1; pendAddr = addr;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic runUntilReq(input bit rdy, input int maxC, output logic [7:0] a);
    logic r;
    logic [7:0] ad;
    bit got;
    got = 0; a = 8'hxx;
    for (int i = 0; i < maxC && !got; i++) begin
      cyc(0, 8'h00, rdy, r, ad);
      if (r) begin got = 1; a = ad; end
    end
    chk("req_within_budget", got, 1);
  endtask

  task automatic doReset();
    rst_n = 1'b0; imem_rvalid = 0; branch_taken = 0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", {x1, x2, instr}, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf", {perf_fetched, perf_flushed}, 0);
`endif
    expQ.delete(); expPc = 8'h00; outstanding = 0; dirty = 0; nPush = 0; nBr = 0;
    if (pend) begin
      if (pendCnt > 0) pendCnt--;
      else pend = 0;
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic       req;
    logic [7:0] addr;
    int         nReq, nLate;
    imem_rvalid = 0; imem_rdata = 0; branch_taken = 0; branch_target = 0; out_ready = 0;
    #2;
    chk("init_req", imem_req, 0);
    chk("init_valid", out_valid, 0);
    chk("init_instr", {x1, x2, instr}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // In-order stream, 1-cycle memory: a request every other cycle.
    lat = 1; nReq = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 8'h00, 1, req, addr);
      chk("cadence", req, (i % 2) == 0);
      if (req) nReq++;
    end
    chk("three_reqs", nReq, 3);

    // Consumer stalled: FIFO fills, requests stop, resume after a pop.
    nLate = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 8'h00, 0, req, addr);
      if (i >= 4 && req) nLate++;
    end
    chk("stall_quiet", nLate, 0);
    chk("stall_full", expQ.size(), 2);
    lat = 3;
    cyc(0, 8'h00, 1, req, addr);
    chk("pop_cycle_noreq", req, 0);
    cyc(0, 8'h00, 0, req, addr);
    chk("resume_req", req, 1);
    cyc(0, 8'h00, 0, req, addr);

    // Reset while waiting; the late response lands in IDLE and must be ignored.
    doReset();
    lat = 1;
    cyc(0, 8'h00, 1, req, addr);
    chk("restart_req", req, 1);
    chk("restart_addr", addr, 8'h00);
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, req, addr);

    // Branch while waiting: the in-flight word is dropped.
    lat = 3;
    runUntilReq(1, 10, addr);
    cyc(1, 8'h40, 1, req, addr);
    runUntilReq(1, 10, addr);
    chk("drop_then_40", addr, 8'h40);

    // Branch coincident with response and a pop.
    lat = 1;
    runUntilReq(1, 10, addr);
    cyc(0, 8'h00, 0, req, addr);
    runUntilReq(0, 4, addr);
    chk("pre_branch_valid", out_valid, 1);
    cyc(1, 8'h80, 1, req, addr);
    chk("branch_flushed", out_valid, 0);
    cyc(0, 8'h00, 1, req, addr);
    chk("idle_after_branch", req, 1);
    chk("fetch_80", addr, 8'h80);

    // Branch in IDLE to the top of memory, then PC wrap.
    cyc(0, 8'h00, 1, req, addr);
    cyc(1, 8'hFF, 1, req, addr);
    chk("br_idle_noreq", req, 0);
    runUntilReq(1, 4, addr);
    chk("fetch_ff", addr, 8'hFF);
    runUntilReq(1, 6, addr);
    chk("wrap_00", addr, 8'h00);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, req, addr);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, nPush);
    chk("perf_flushed", perf_flushed, nBr);
`endif

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
